mem_boot_arbiter: RTL
=====================

// Module: mem_boot_arbiter
// PURPOSE
//   Owns the single port of the 16-bit unified memory.
//   Out of reset it streams a boot image into memory from word 0 and zero-fills the rest.
//   It then releases the processor and arbitrates each memory cycle between the processor and a debug/DMA port.
//   Replaces ad-hoc rst-muxing of memory address/data/we between loader and processor.
// PARAMETERS
//   DATA_W      16    memory word width
//   ADDR_W      16    memory address width
//   DEPTH       1024  words loaded/zero-filled at boot (<= 2**ADDR_W)
//   STARVE_MAX  8     consecutive blocked debug cycles before debug is forced through
//   FILL_ZERO   1     1: zero-fill words after last loaded word; 0: go straight to RUN
// PORTS
//   clk         in   1       single clock, all state on rising edge
//   rst         in   1       asynchronous reset, ACTIVE-LOW
//   ld_valid    in   1       boot word valid
//   ld_data     in   DATA_W  boot word
//   ld_last     in   1       qualifies ld_valid: final boot word
//   ld_ready    out  1       arbiter accepts boot word this cycle
//   cpu_req     in   1       processor memory access this cycle
//   cpu_we      in   1       processor write enable
//   cpu_addr    in   ADDR_W  processor address
//   cpu_wdata   in   DATA_W  processor write data
//   cpu_rdata   out  DATA_W  = mem_rdata
//   cpu_run     out  1       processor may leave reset/fetch
//   cpu_stall   out  1       processor access not performed this cycle; hold and retry
//   dbg_req     in   1       debug access request (held until granted)
//   dbg_we      in   1       debug write enable
//   dbg_addr    in   ADDR_W  debug address
//   dbg_wdata   in   DATA_W  debug write data
//   dbg_gnt     out  1       debug access performed this cycle
//   dbg_rdata   out  DATA_W  = mem_rdata
//   dbg_rvalid  out  1       pulses 1 cycle after a granted debug read
//   mem_we      out  1       memory write enable
//   mem_addr    out  ADDR_W  memory address
//   mem_wdata   out  DATA_W  memory write data
//   mem_rdata   in   DATA_W  memory read data (1-cycle registered read)
//   boot_done   out  1       = cpu_run
//   load_ovf    out  1       sticky: ld_valid seen after load closed
// BEHAVIOUR
//   Reset (rst=0, async): state=LOAD, ptr=0, starve=0, cpu_run=0, load_ovf=0, dbg_rvalid=0.
//   Combinational outputs while in reset: ld_ready=1, mem_we=0, dbg_gnt=0, cpu_stall=0.
//   FSM LOAD -> FILL -> RUN; RUN is terminal until reset.
//   LOAD:
//     - ld_ready=1.
//     - On beat: mem_we=1, mem_addr=ptr, mem_wdata=ld_data, same cycle; ptr++.
//     - Beat with ld_last or ptr==DEPTH-1 closes load:
//       to FILL if FILL_ZERO && ptr<DEPTH-1, else to RUN.
//     - No beat: mem_we=0.
//   FILL:
//     - ld_ready=0; every cycle mem_we=1, mem_addr=ptr, mem_wdata=0; ptr++.
//     - Write at ptr==DEPTH-1 -> RUN.
//   RUN:
//     - cpu_run=1, registered, first RUN cycle; ld_ready=0.
//     - ld_valid in FILL/RUN sets load_ovf.
//   Arbitration, RUN only; cpu_req and dbg_req ignored before RUN:
//     - Default: cpu_req wins.
//       mem_* from cpu_*, mem_we=cpu_req&cpu_we; dbg_gnt=dbg_req&!cpu_req.
//     - starve++ each cycle dbg_req&cpu_req&!dbg_gnt, saturating at STARVE_MAX.
//     - starve==STARVE_MAX forces dbg_gnt=1, cpu_stall=cpu_req, mem_* from dbg_*.
//     - starve clears on any dbg_gnt.
//     - dbg_rvalid <= dbg_gnt & !dbg_we.
//     - No requester: mem_we=0, mem_addr=cpu_addr.
//   Widths: ptr is ADDR_W+1 bits, never wraps; DEPTH==1 goes LOAD->RUN on first beat.
// STRUCTURE
//   Shared package: state enum {LOAD,FILL,RUN}, DATA_W/ADDR_W defaults.
//   Optional sub-module mem_port_mux: one-hot select of {loader, fill, cpu, dbg} onto mem_*.
//   Arbiter and starve counter stay inline.
// TESTING
//   1. DEPTH=8: 3 beats A1,A2,A3 + ld_last -> writes 0..2; zeros at 3..7 on 5 consecutive cycles; cpu_run next.
//   2. 8 beats, no ld_last -> RUN directly after addr 7, no FILL cycles; 9th ld_valid -> load_ovf=1, ld_ready=0.
//   3. RUN, cpu_req=1 held, dbg_req=1 read addr 5 -> dbg_gnt on 9th cycle (STARVE_MAX=8).
//      That cycle: cpu_stall=1; dbg_rvalid next cycle with mem[5].
//   4. RUN, cpu_req=0, dbg write 0xBEEF@0x10 -> dbg_gnt same cycle, mem_we=1; later cpu read 0x10 returns 0xBEEF.
//   5. rst low mid-FILL at ptr=4 -> outputs to reset values immediately.
//      Release -> LOAD, ptr=0, cpu_run=0.
//   6. ld_valid with ld_ready gaps (valid toggling) -> only handshaken beats written, addresses contiguous.

Source files
------------

// File: rtl/mem_boot_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_boot_arbiter_pkg
// Brief  : Shared types and defaults for the boot loader / memory arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package mem_boot_arbiter_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

  // Boot sequencing: stream image, zero-fill remainder, then normal run.
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Bit positions of the one-hot memory port source select.
  localparam int SEL_LD   = 0;
  localparam int SEL_FILL = 1;
  localparam int SEL_CPU  = 2;
  localparam int SEL_DBG  = 3;
  localparam int SEL_W    = 4;

endpackage
`default_nettype wire

// File: rtl/mem_boot_arbiter_mem_port_mux.sv
`default_nettype none
// ============================================================================
// Module : mem_boot_arbiter_mem_port_mux
// Brief  : One-hot AND-OR select of loader / fill / cpu / debug onto the
//          single memory port. With no source selected the port idles on the
//          cpu address with write enable low.
// Rev    : 1.0  initial release
// ============================================================================
module mem_boot_arbiter_mem_port_mux
  import mem_boot_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [SEL_W-1:0]  sel,
  input  logic [ADDR_W-1:0] ptr_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  // Loader and fill always write; cpu/debug write only when they ask to.
  always_comb begin
    mem_we    = (sel[SEL_LD] | sel[SEL_FILL])
              | (sel[SEL_CPU] & cpu_we)
              | (sel[SEL_DBG] & dbg_we);
    mem_wdata = ({DATA_W{sel[SEL_LD]}}  & ld_data)
              | ({DATA_W{sel[SEL_CPU]}} & cpu_wdata)
              | ({DATA_W{sel[SEL_DBG]}} & dbg_wdata);
    if (sel == '0) begin
      mem_addr = cpu_addr;
    end else begin
      mem_addr = ({ADDR_W{sel[SEL_LD] | sel[SEL_FILL]}} & ptr_addr)
               | ({ADDR_W{sel[SEL_CPU]}} & cpu_addr)
               | ({ADDR_W{sel[SEL_DBG]}} & dbg_addr);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_boot_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_boot_arbiter
// Brief  : Owns the unified memory port. Streams a boot image from word 0,
//          optionally zero-fills the rest, then releases the cpu and
//          arbitrates each cycle between cpu and debug/DMA with an
//          anti-starvation counter for debug.
// Rev    : 1.0  initial release
// ============================================================================
module mem_boot_arbiter
  import mem_boot_arbiter_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH      = 1024,
  parameter int STARVE_MAX = 8,
  parameter bit FILL_ZERO  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_run,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              boot_done,
  output logic              load_ovf
);

  localparam int              STARVE_W   = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  // ptr carries one extra bit so it can reach DEPTH without wrapping.
  localparam logic [ADDR_W:0] LAST_PTR   = (ADDR_W+1)'(DEPTH - 1);

  state_t              state;
  logic [ADDR_W:0]     ptr;
  logic [STARVE_W-1:0] starve;

  logic             in_load;
  logic             in_fill;
  logic             in_run;
  logic             beat;
  logic             ptr_last;
  logic             starve_full;
  logic [SEL_W-1:0] sel;

  assign in_load     = (state == ST_LOAD);
  assign in_fill     = (state == ST_FILL);
  assign in_run      = (state == ST_RUN);
  assign ptr_last    = (ptr == LAST_PTR);
  assign starve_full = (starve == STARVE_LIM);

  // A beat needs reset released so nothing reaches memory while held in reset.
  assign beat      = rst & in_load & ld_valid;
  assign ld_ready  = in_load;
  assign dbg_gnt   = in_run & dbg_req & (starve_full | ~cpu_req);
  assign cpu_stall = in_run & cpu_req & dbg_gnt;
  assign cpu_rdata = mem_rdata;
  assign dbg_rdata = mem_rdata;
  assign boot_done = cpu_run;

  // Choose which source owns the memory port this cycle.
  always_comb begin
    sel = '0;
    case (state)
      ST_LOAD: sel[SEL_LD]   = beat;
      ST_FILL: sel[SEL_FILL] = 1'b1;
      ST_RUN: begin
        if (dbg_gnt) begin
          sel[SEL_DBG] = 1'b1;
        end else if (cpu_req) begin
          sel[SEL_CPU] = 1'b1;
        end
      end
      default: sel = '0;
    endcase
  end

  mem_boot_arbiter_mem_port_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mux (
    .sel       (sel),
    .ptr_addr  (ptr[ADDR_W-1:0]),
    .ld_data   (ld_data),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  // Boot FSM, write pointer, starvation counter and registered flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_LOAD;
      ptr        <= '0;
      starve     <= '0;
      cpu_run    <= 1'b0;
      load_ovf   <= 1'b0;
      dbg_rvalid <= 1'b0;
    end else begin
      dbg_rvalid <= dbg_gnt & ~dbg_we;
      if (ld_valid && !in_load) begin
        load_ovf <= 1'b1;
      end
      case (state)
        ST_LOAD: begin
          if (beat) begin
            ptr <= ptr + 1'b1;
            if (ld_last || ptr_last) begin
              if (FILL_ZERO && (ptr < LAST_PTR)) begin
                state <= ST_FILL;
              end else begin
                state   <= ST_RUN;
                cpu_run <= 1'b1;
              end
            end
          end
        end
        ST_FILL: begin
          ptr <= ptr + 1'b1;
          if (ptr_last) begin
            state   <= ST_RUN;
            cpu_run <= 1'b1;
          end
        end
        ST_RUN: begin
          if (dbg_gnt) begin
            starve <= '0;
          end else if (dbg_req && cpu_req && !starve_full) begin
            starve <= starve + 1'b1;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule
`default_nettype wire
